// File: rtl/dwt_row_arbiter.sv
// dwt_row_arbiter: shares one row-DWT engine between two line requesters.
// A requester owns the forward path from its first beat until the DWT accepts
// its eol beat. Each granted line pushes its owner tag into a small FIFO so
// results returning from the DWT can be steered back to the right consumer.
module dwt_row_arbiter #(
    parameter int DataWidth = 16,
    parameter int TagDepth  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    // requester 0
    output logic                     s0_ready_o,
    input  logic                     s0_valid_i,
    input  logic                     s0_sof_i,
    input  logic                     s0_eol_i,
    input  logic [2*DataWidth-1:0]   s0_data_i,

    // requester 1
    output logic                     s1_ready_o,
    input  logic                     s1_valid_i,
    input  logic                     s1_sof_i,
    input  logic                     s1_eol_i,
    input  logic [2*DataWidth-1:0]   s1_data_i,

    // towards the shared row DWT
    input  logic                     d_ready_i,
    output logic                     d_valid_o,
    output logic                     d_sof_o,
    output logic                     d_eol_o,
    output logic [2*DataWidth-1:0]   d_data_o,

    // back from the shared row DWT
    output logic                     r_ready_o,
    input  logic                     r_valid_i,
    input  logic                     r_sof_i,
    input  logic                     r_eol_i,
    input  logic [2*DataWidth-1:0]   r_data_i,

    // result stream for requester 0
    input  logic                     m0_ready_i,
    output logic                     m0_valid_o,
    output logic                     m0_sof_o,
    output logic                     m0_eol_o,
    output logic [2*DataWidth-1:0]   m0_data_o,

    // result stream for requester 1
    input  logic                     m1_ready_i,
    output logic                     m1_valid_o,
    output logic                     m1_sof_o,
    output logic                     m1_eol_o,
    output logic [2*DataWidth-1:0]   m1_data_o,

    output logic                     busy_o
);

    localparam int BeatW = 2 * DataWidth;
    localparam int PtrW  = (TagDepth > 2) ? $clog2(TagDepth) : 1;
    localparam int CntW  = PtrW + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // requester / consumer ports gathered into indexable form
    logic [1:0]       s_valid;
    logic [1:0]       s_sof;
    logic [1:0]       s_eol;
    logic [BeatW-1:0] s_data [2];
    logic [1:0]       s_ready;
    logic [1:0]       m_ready;
    logic [1:0]       m_valid;

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             rr_reg, rr_next;

    // owner tag FIFO
    logic             tag_mem [TagDepth];
    logic [PtrW-1:0]  wr_ptr_reg;
    logic [PtrW-1:0]  rd_ptr_reg;
    logic [CntW-1:0]  count_reg;

    logic             push;
    logic             push_tag;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head_tag;
    logic             out_en;
    logic             fwd_active;
    logic             ret_active;

    assign s_valid   = {s1_valid_i, s0_valid_i};
    assign s_sof     = {s1_sof_i, s0_sof_i};
    assign s_eol     = {s1_eol_i, s0_eol_i};
    assign s_data[0] = s0_data_i;
    assign s_data[1] = s1_data_i;
    assign m_ready   = {m1_ready_i, m0_ready_i};

    assign s0_ready_o = s_ready[0];
    assign s1_ready_o = s_ready[1];
    assign m0_valid_o = m_valid[0];
    assign m1_valid_o = m_valid[1];

    // Outputs are forced quiet while reset is held, so nothing leaks out
    // before the state registers have been cleared on the first edge.
    assign out_en     = ~rst_i;
    assign fifo_full  = (count_reg == CntW'(TagDepth));
    assign fifo_empty = (count_reg == '0);
    assign head_tag   = tag_mem[rd_ptr_reg];
    assign fwd_active = out_en & (state_reg == ST_BUSY);
    assign ret_active = out_en & ~fifo_empty;

    // Next-state logic: grant in IDLE, release on accepted owner eol in BUSY.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        push       = 1'b0;
        push_tag   = 1'b0;
        if (state_reg == ST_IDLE) begin
            // Never grant while every tag slot is taken; the line would have
            // nowhere to record its owner.
            if (!fifo_full && (s_valid != 2'b00)) begin
                push_tag   = (s_valid == 2'b11) ? rr_reg : s_valid[1];
                push       = 1'b1;
                owner_next = push_tag;
                state_next = ST_BUSY;
            end
        end else begin
            if (s_valid[owner_reg] && d_ready_i && s_eol[owner_reg]) begin
                state_next = ST_IDLE;
                rr_next    = ~owner_reg;
            end
        end
    end

    // Forward path: owner beats go straight through to the DWT.
    assign d_valid_o = fwd_active & s_valid[owner_reg];
    assign d_sof_o   = s_sof[owner_reg];
    assign d_eol_o   = s_eol[owner_reg];
    assign d_data_o  = s_data[owner_reg];

    // Return path: the FIFO head decides which consumer sees the DWT output.
    assign r_ready_o = ret_active & m_ready[head_tag];
    assign pop       = r_valid_i & r_ready_o & r_eol_i;

    assign m0_sof_o  = r_sof_i;
    assign m0_eol_o  = r_eol_i;
    assign m0_data_o = r_data_i;
    assign m1_sof_o  = r_sof_i;
    assign m1_eol_o  = r_eol_i;
    assign m1_data_o = r_data_i;

    // Per-requester ready and per-consumer valid steering.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign s_ready[gi] = fwd_active & (owner_reg == 1'(gi)) & d_ready_i;
            assign m_valid[gi] = ret_active & (head_tag == 1'(gi)) & r_valid_i;
        end
    endgenerate

    assign busy_o = out_en & ((state_reg == ST_BUSY) | ~fifo_empty);

    // Arbiter state, owner and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            owner_reg <= 1'b0;
            rr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Tag storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= push_tag;
        end
    end

endmodule

// File: tb/tb_dwt_row_arbiter.sv
// Directed bench for dwt_row_arbiter: single line, contention, tag-full stall,
// forward backpressure, simultaneous push/pop and reset in mid-line.
module tb_dwt_row_arbiter;

    localparam int DW = 16;
    localparam int BW = 2 * DW;

    logic          clk_i;
    logic          rst_i;
    logic          s0_ready_o, s0_valid_i, s0_sof_i, s0_eol_i;
    logic [BW-1:0] s0_data_i;
    logic          s1_ready_o, s1_valid_i, s1_sof_i, s1_eol_i;
    logic [BW-1:0] s1_data_i;
    logic          d_ready_i, d_valid_o, d_sof_o, d_eol_o;
    logic [BW-1:0] d_data_o;
    logic          r_ready_o, r_valid_i, r_sof_i, r_eol_i;
    logic [BW-1:0] r_data_i;
    logic          m0_ready_i, m0_valid_o, m0_sof_o, m0_eol_o;
    logic [BW-1:0] m0_data_o;
    logic          m1_ready_i, m1_valid_o, m1_sof_o, m1_eol_o;
    logic [BW-1:0] m1_data_o;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    dwt_row_arbiter #(.DataWidth(DW), .TagDepth(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s0_ready_o(s0_ready_o), .s0_valid_i(s0_valid_i), .s0_sof_i(s0_sof_i),
        .s0_eol_i(s0_eol_i), .s0_data_i(s0_data_i),
        .s1_ready_o(s1_ready_o), .s1_valid_i(s1_valid_i), .s1_sof_i(s1_sof_i),
        .s1_eol_i(s1_eol_i), .s1_data_i(s1_data_i),
        .d_ready_i(d_ready_i), .d_valid_o(d_valid_o), .d_sof_o(d_sof_o),
        .d_eol_o(d_eol_o), .d_data_o(d_data_o),
        .r_ready_o(r_ready_o), .r_valid_i(r_valid_i), .r_sof_i(r_sof_i),
        .r_eol_i(r_eol_i), .r_data_i(r_data_i),
        .m0_ready_i(m0_ready_i), .m0_valid_o(m0_valid_o), .m0_sof_o(m0_sof_o),
        .m0_eol_o(m0_eol_o), .m0_data_o(m0_data_o),
        .m1_ready_i(m1_ready_i), .m1_valid_o(m1_valid_o), .m1_sof_o(m1_sof_o),
        .m1_eol_o(m1_eol_o), .m1_data_o(m1_data_o),
        .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid_i = 0; s0_sof_i = 0; s0_eol_i = 0; s0_data_i = '0;
        s1_valid_i = 0; s1_sof_i = 0; s1_eol_i = 0; s1_data_i = '0;
        d_ready_i  = 1;
        r_valid_i  = 0; r_sof_i = 0; r_eol_i = 0; r_data_i = '0;
        m0_ready_i = 1; m1_ready_i = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
    endtask

    initial begin
        // ---------------- reset: outputs quiet while rst_i is high
        idle_inputs();
        rst_i = 1;
        s0_valid_i = 1; s1_valid_i = 1; r_valid_i = 1; r_eol_i = 1;
        #1;
        check_eq("rst_d_valid",  32'(d_valid_o),  0);
        check_eq("rst_s0_ready", 32'(s0_ready_o), 0);
        check_eq("rst_s1_ready", 32'(s1_ready_o), 0);
        check_eq("rst_r_ready",  32'(r_ready_o),  0);
        check_eq("rst_m0_valid", 32'(m0_valid_o), 0);
        check_eq("rst_m1_valid", 32'(m1_valid_o), 0);
        check_eq("rst_busy",     32'(busy_o),     0);
        tick();
        tick();
        rst_i = 0;
        idle_inputs();
        #1;
        check_eq("post_rst_busy",    32'(busy_o),    0);
        check_eq("post_rst_d_valid", 32'(d_valid_o), 0);
        $display("txn reset checked");

        // ---------------- single 4-beat line from s0
        s0_valid_i = 1; s0_sof_i = 1; s0_eol_i = 0; s0_data_i = 32'hA000_0000;
        #1;
        check_eq("single_bubble_dv", 32'(d_valid_o),  0);
        check_eq("single_bubble_rd", 32'(s0_ready_o), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            s0_sof_i = (i == 0); s0_eol_i = (i == 3); s0_data_i = 32'hA000_0000 + 32'(i);
            #1;
            check_eq("single_d_valid",  32'(d_valid_o),  1);
            check_eq("single_d_data",   d_data_o,        32'hA000_0000 + 32'(i));
            check_eq("single_d_sof",    32'(d_sof_o),    32'(i == 0));
            check_eq("single_d_eol",    32'(d_eol_o),    32'(i == 3));
            check_eq("single_s0_ready", 32'(s0_ready_o), 1);
            check_eq("single_s1_ready", 32'(s1_ready_o), 0);
            tick();
        end
        s0_valid_i = 0; s0_eol_i = 0; s0_sof_i = 0;
        #1;
        check_eq("single_busy_pending", 32'(busy_o),     1);
        check_eq("single_m0_idle",      32'(m0_valid_o), 0);
        check_eq("single_after_dv",     32'(d_valid_o),  0);
        for (int i = 0; i < 4; i++) begin
            r_valid_i = 1; r_sof_i = (i == 0); r_eol_i = (i == 3);
            r_data_i = 32'hC000_0000 + 32'(i);
            #1;
            check_eq("ret_m0_valid", 32'(m0_valid_o), 1);
            check_eq("ret_m1_valid", 32'(m1_valid_o), 0);
            check_eq("ret_m0_data",  m0_data_o,       32'hC000_0000 + 32'(i));
            check_eq("ret_m0_eol",   32'(m0_eol_o),   32'(i == 3));
            check_eq("ret_r_ready",  32'(r_ready_o),  1);
            tick();
        end
        r_valid_i = 0; r_eol_i = 0; r_sof_i = 0;
        #1;
        check_eq("single_busy_done", 32'(busy_o),    0);
        check_eq("single_r_ready0",  32'(r_ready_o), 0);
        $display("txn single line s0 -> m0");

        // ---------------- contention: expect s0, s1, s0 with bubbles
        do_reset();
        s0_valid_i = 1; s0_sof_i = 1; s0_eol_i = 1; s0_data_i = 32'h5000_0000;
        s1_valid_i = 1; s1_sof_i = 1; s1_eol_i = 1; s1_data_i = 32'h5100_0000;
        for (int k = 0; k < 3; k++) begin
            int own;
            own = (k == 1) ? 1 : 0;
            #1;
            check_eq("cont_bubble_dv", 32'(d_valid_o),  0);
            check_eq("cont_bubble_r0", 32'(s0_ready_o), 0);
            check_eq("cont_bubble_r1", 32'(s1_ready_o), 0);
            tick();
            check_eq("cont_d_data",   d_data_o, (own == 1) ? 32'h5100_0000 : 32'h5000_0000);
            check_eq("cont_s0_ready", 32'(s0_ready_o), 32'(own == 0));
            check_eq("cont_s1_ready", 32'(s1_ready_o), 32'(own == 1));
            tick();
            $display("txn contention line %0d granted to s%0d", k, own);
        end
        // tags now 0,1,0; grant s1 while the head (tag 0) returns its eol
        r_valid_i = 1; r_sof_i = 1; r_eol_i = 1; r_data_i = 32'hD000_0000;
        #1;
        check_eq("pp_m0_valid", 32'(m0_valid_o), 1);
        check_eq("pp_m1_valid", 32'(m1_valid_o), 0);
        check_eq("pp_d_valid",  32'(d_valid_o),  0);
        tick();
        s0_valid_i = 0;
        r_data_i = 32'hD000_0001;
        #1;
        check_eq("pp_s1_ready",  32'(s1_ready_o), 1);
        check_eq("pp_d_data",    d_data_o,        32'h5100_0000);
        check_eq("pp_ret1_m1",   32'(m1_valid_o), 1);
        check_eq("pp_ret1_m0",   32'(m0_valid_o), 0);
        check_eq("pp_ret1_data", m1_data_o,       32'hD000_0001);
        tick();
        s1_valid_i = 0;
        #1;
        check_eq("pp_ret2_m0", 32'(m0_valid_o), 1);
        check_eq("pp_ret2_m1", 32'(m1_valid_o), 0);
        tick();
        #1;
        check_eq("pp_ret3_m1", 32'(m1_valid_o), 1);
        check_eq("pp_ret3_m0", 32'(m0_valid_o), 0);
        tick();
        r_valid_i = 0;
        #1;
        check_eq("pp_busy_done", 32'(busy_o), 0);
        $display("txn simultaneous push/pop, returns 0,1,0,1");

        // ---------------- tag FIFO full: fifth line stalls until a pop
        do_reset();
        s0_valid_i = 1; s0_sof_i = 1; s0_eol_i = 1; s0_data_i = 32'h7000_0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("full_grant_dv", 32'(d_valid_o), 1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check_eq("full_stall_dv", 32'(d_valid_o),  0);
            check_eq("full_stall_rd", 32'(s0_ready_o), 0);
            check_eq("full_busy",     32'(busy_o),     1);
            tick();
        end
        r_valid_i = 1; r_sof_i = 1; r_eol_i = 1;
        #1;
        check_eq("full_pop_m0", 32'(m0_valid_o), 1);
        check_eq("full_pop_dv", 32'(d_valid_o),  0);
        tick();
        r_valid_i = 0;
        #1;
        check_eq("full_regrant_bubble", 32'(d_valid_o), 0);
        tick();
        check_eq("full_regrant_dv", 32'(d_valid_o),  1);
        check_eq("full_regrant_rd", 32'(s0_ready_o), 1);
        tick();
        s0_valid_i = 0;
        $display("txn tag-full stall released by one pop");

        // ---------------- forward backpressure with a waiting s1
        do_reset();
        s1_valid_i = 1; s1_sof_i = 1; s1_eol_i = 1; s1_data_i = 32'h9100_0000;
        s0_valid_i = 1; s0_sof_i = 1; s0_eol_i = 0; s0_data_i = 32'h9000_0000;
        tick();
        begin
            int idx;
            int cyc;
            idx = 0;
            cyc = 0;
            while (idx < 4 && cyc < 20) begin
                d_ready_i = (cyc % 2) == 1;
                s0_sof_i = (idx == 0); s0_eol_i = (idx == 3);
                s0_data_i = 32'h9000_0000 + 32'(idx);
                #1;
                check_eq("bp_d_data",   d_data_o,        32'h9000_0000 + 32'(idx));
                check_eq("bp_s0_ready", 32'(s0_ready_o), 32'(d_ready_i));
                check_eq("bp_s1_ready", 32'(s1_ready_o), 0);
                tick();
                if (d_ready_i) idx++;
                cyc++;
            end
            check_eq("bp_beats_done", 32'(idx), 4);
        end
        s0_valid_i = 0; d_ready_i = 1;
        #1;
        check_eq("bp_bubble_dv", 32'(d_valid_o), 0);
        tick();
        check_eq("bp_next_s1", 32'(s1_ready_o), 1);
        check_eq("bp_next_dd", d_data_o,        32'h9100_0000);
        tick();
        s1_valid_i = 0;
        $display("txn backpressure line s0 then s1");

        // ---------------- reset on beat 2 of a 4-beat line
        do_reset();
        s0_valid_i = 1; s0_sof_i = 1; s0_eol_i = 0; s0_data_i = 32'hB000_0000;
        tick();
        for (int i = 0; i < 2; i++) begin
            s0_sof_i = (i == 0); s0_data_i = 32'hB000_0000 + 32'(i);
            tick();
        end
        s0_sof_i = 0; s0_data_i = 32'hB000_0002;
        rst_i = 1;
        #1;
        check_eq("mid_rst_dv", 32'(d_valid_o), 0);
        tick();
        rst_i = 0;
        s0_valid_i = 0;
        s1_valid_i = 1; s1_sof_i = 1; s1_eol_i = 1; s1_data_i = 32'hB100_0000;
        #1;
        check_eq("mid_after_busy", 32'(busy_o),     0);
        check_eq("mid_after_dv",   32'(d_valid_o),  0);
        check_eq("mid_after_r0",   32'(s0_ready_o), 0);
        check_eq("mid_after_r1",   32'(s1_ready_o), 0);
        tick();
        check_eq("mid_s1_dv",    32'(d_valid_o),  1);
        check_eq("mid_s1_data",  d_data_o,        32'hB100_0000);
        check_eq("mid_s1_ready", 32'(s1_ready_o), 1);
        tick();
        s1_valid_i = 0;
        $display("txn reset mid-line then s1 line");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
